// File: rtl/init.sv
// -----------------------------------------------------------------------------
// init -- S-memory initialisation engine for the ARC4 decrypter datapath.
//
// On an accepted start request it writes the identity permutation S[i] = i
// into a 256 x 8 single-port RAM, one word per clock, addresses 0..255 in
// ascending order. It never reads the memory.
//
// Ports:
//   clk     in   1  system clock, rising edge active
//   rst_n   in   1  synchronous reset, active HIGH despite the name
//   en      in   1  start request, accepted on an edge where rdy = 1
//   rdy     out  1  1 = idle and able to accept en, 0 = fill in progress
//   addr    out  8  S-memory write address
//   wrdata  out  8  S-memory write data (always equal to addr while writing)
//   wren    out  1  S-memory write enable
// -----------------------------------------------------------------------------
module init (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] addr,
  output logic [7:0] wrdata,
  output logic       wren
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    case (state_q)
      IDLE: begin
        i_d = 8'd0;
        if (en) begin
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // The counter wraps 255 -> 0 naturally; the last-write check looks at
        // the current value, so no ninth bit is needed.
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          // A request present on the final write edge chains straight into a
          // new fill so back-to-back fills have no idle gap.
          if (en) begin
            state_d = FILL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
        i_d     = 8'd0;
      end
    endcase
  end

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
    end
  end

  // Moore output decode from registered state and counter only.
  always_comb begin
    rdy    = 1'b1;
    wren   = 1'b0;
    addr   = 8'd0;
    wrdata = 8'd0;
    case (state_q)
      IDLE: begin
        rdy    = 1'b1;
        wren   = 1'b0;
        addr   = 8'd0;
        wrdata = 8'd0;
      end
      FILL: begin
        rdy    = 1'b0;
        wren   = 1'b1;
        addr   = i_q;
        wrdata = i_q;
      end
      default: begin
        rdy    = 1'b1;
        wren   = 1'b0;
        addr   = 8'd0;
        wrdata = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_init.sv
// -----------------------------------------------------------------------------
// tb_init -- scoreboard bench for init.
// A reference process watches the bench-driven inputs at each rising edge and
// queues the 256 expected write addresses whenever a fill should be accepted.
// A monitor on the falling edge pops and compares every write the DUT makes
// and checks rdy / wren / idle outputs against the reference state.
// -----------------------------------------------------------------------------
module tb_init;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] addr;
  logic [7:0] wrdata;
  logic       wren;

  int n_cmp;
  int n_bad;

  // Reference state.
  logic       m_busy;
  logic [7:0] m_i;
  logic [7:0] exp_q[$];

  // Memory model written by the monitor.
  logic [7:0] mem [256];

  init dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .addr   (addr),
    .wrdata (wrdata),
    .wren   (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_fill();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] a;
      a = k[7:0];
      exp_q.push_back(a);
    end
  endtask

  // Reference behaviour, updated on the same edge the DUT samples.
  initial begin
    m_busy = 1'b0;
    m_i    = 8'd0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        m_busy = 1'b0;
        m_i    = 8'd0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (en) begin
          m_busy = 1'b1;
          m_i    = 8'd0;
          push_fill();
        end
      end else begin
        if (m_i == 8'd255) begin
          m_i = 8'd0;
          if (en) push_fill();
          else    m_busy = 1'b0;
        end else begin
          m_i = m_i + 8'd1;
        end
      end
    end
  end

  // Monitor: sample outputs mid-cycle and compare against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (rdy !== !m_busy) begin
        n_bad++;
        $display("FAIL rdy: got %0b expected %0b at %0t", rdy, !m_busy, $time);
      end
      n_cmp++;
      if (wren !== m_busy) begin
        n_bad++;
        $display("FAIL wren: got %0b expected %0b at %0t", wren, m_busy, $time);
      end
      if (wren === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: addr %0d with nothing expected at %0t", addr, $time);
        end else begin
          e = exp_q.pop_front();
          if (addr !== e || wrdata !== e) begin
            n_bad++;
            $display("FAIL write: got addr %0d data %0d expected %0d at %0t",
                     addr, wrdata, e, $time);
          end
        end
        mem[addr] = wrdata;
      end else begin
        n_cmp++;
        if (addr !== 8'd0 || wrdata !== 8'd0) begin
          n_bad++;
          $display("FAIL idle_outputs: got addr %0d data %0d expected 0/0 at %0t",
                   addr, wrdata, $time);
        end
      end
    end
  end

  // Wait (bounded) until rdy is high; returns the number of edges waited.
  task automatic wait_idle(input int limit, output int edges);
    edges = 0;
    while (rdy !== 1'b1 && edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_timeout: rdy %0b after %0d edges, expected 1", rdy, edges);
    end
  endtask

  // One-cycle en pulse, starting 1 ns after a rising edge.
  task automatic pulse_en();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic check_busy_len(input string name, input int got);
    n_cmp++;
    if (got != 256) begin
      n_bad++;
      $display("FAIL %s: busy edges %0d expected 256", name, got);
    end
  endtask

  initial begin
    int edges;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    en    = 1'b0;

    // Reset for two cycles, then 27 idle cycles with no writes.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (27) @(posedge clk);
    #1;

    // Full fill with a memory model check afterwards.
    for (int k = 0; k < 256; k++) begin
      logic [7:0] v;
      v = k[7:0];
      mem[k] = ~v;
    end
    pulse_en();
    wait_idle(300, edges);
    check_busy_len("full_fill_len", edges);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] v;
      v = k[7:0];
      n_cmp++;
      if (mem[k] !== v) begin
        n_bad++;
        $display("FAIL mem_content: S[%0d] = %0d expected %0d", k, mem[k], v);
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-fill, then a fresh fill from address 0.
    pulse_en();
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    n_cmp++;
    if (rdy !== 1'b1 || wren !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: rdy %0b wren %0b expected 1/0", rdy, wren);
    end
    repeat (4) @(posedge clk);
    #1;
    pulse_en();
    wait_idle(300, edges);
    check_busy_len("restart_fill_len", edges);
    repeat (2) @(posedge clk);
    #1;

    // en re-asserted while busy is ignored.
    pulse_en();
    repeat (26) @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_idle(300, edges);
    check_busy_len("busy_en_len", edges + 27);
    repeat (2) @(posedge clk);
    #1;

    // Continuous en: back-to-back fills with no idle gap.
    en = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    en = 1'b0;
    wait_idle(600, edges);
    repeat (5) @(posedge clk);
    #1;

    // Every expected write must have been consumed.
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL write_count: %0d expected writes outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
